// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues one data-memory request per load/store,
// stalls upstream until the ack, and registers the writeback result.
module mem_access_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     InValid,
    input  logic [DATA_WIDTH-1:0]    ALUOutIn,
    input  logic [DATA_WIDTH-1:0]    RdDataBIn,
    input  logic                     IsLoadInsnIn,
    input  logic                     IsStoreInsnIn,
    input  logic                     RfWrEnableIn,
    input  logic [REG_NUM_WIDTH-1:0] WrNumIn,
    input  logic                     Flush,
    output logic                     Stall,
    output logic                     DmReq,
    output logic                     DmWe,
    output logic [DATA_WIDTH-1:0]    DmAddr,
    output logic [DATA_WIDTH-1:0]    DmWdata,
    input  logic                     DmAck,
    input  logic [DATA_WIDTH-1:0]    DmRdata,
    output logic                     WbValid,
    output logic                     WbRfWrEnable,
    output logic [REG_NUM_WIDTH-1:0] WbWrNum,
    output logic [DATA_WIDTH-1:0]    WbData,
    output logic                     MisalignErr
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                   state_q, state_d;
    logic                     dm_req_q, dm_req_d;
    logic                     dm_we_q, dm_we_d;
    logic [DATA_WIDTH-1:0]    dm_addr_q, dm_addr_d;
    logic [DATA_WIDTH-1:0]    dm_wdata_q, dm_wdata_d;
    logic [REG_NUM_WIDTH-1:0] lat_num_q, lat_num_d;
    logic                     lat_rfwe_q, lat_rfwe_d;
    logic                     wb_valid_q, wb_valid_d;
    logic                     wb_rfwe_q, wb_rfwe_d;
    logic [REG_NUM_WIDTH-1:0] wb_num_q, wb_num_d;
    logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                     mis_q, mis_d;

    logic is_mem, aligned, start;

    assign is_mem  = IsLoadInsnIn | IsStoreInsnIn;
    assign aligned = (ALUOutIn[1:0] == 2'b00);
    assign start   = (state_q == IDLE) & InValid & is_mem & aligned & ~Flush;
    // Nothing is accepted while reset is held, so upstream must not be told to hold.
    assign Stall   = rst & (start | ((state_q == WAIT) & ~DmAck));

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        lat_num_d  = lat_num_q;
        lat_rfwe_d = lat_rfwe_q;
        wb_valid_d = 1'b0;
        wb_rfwe_d  = wb_rfwe_q;
        wb_num_d   = wb_num_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Flush) begin
                    wb_rfwe_d = 1'b0;
                end else if (InValid && is_mem && !aligned) begin
                    wb_valid_d = 1'b1;
                    wb_rfwe_d  = 1'b0;
                    mis_d      = 1'b1;
                end else if (start) begin
                    state_d    = WAIT;
                    dm_req_d   = 1'b1;
                    dm_we_d    = IsStoreInsnIn;
                    dm_addr_d  = ALUOutIn;
                    dm_wdata_d = RdDataBIn;
                    lat_num_d  = WrNumIn;
                    lat_rfwe_d = RfWrEnableIn;
                    wb_rfwe_d  = 1'b0;
                end else if (InValid) begin
                    wb_valid_d = 1'b1;
                    wb_rfwe_d  = RfWrEnableIn;
                    wb_num_d   = WrNumIn;
                    wb_data_d  = ALUOutIn;
                end else begin
                    wb_rfwe_d = 1'b0;
                end
            end
            WAIT: begin
                // Flush is deliberately ignored: the bus transaction must finish.
                if (DmAck) begin
                    state_d    = IDLE;
                    dm_req_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_num_d   = lat_num_q;
                    wb_rfwe_d  = lat_rfwe_q & ~dm_we_q;
                    wb_data_d  = dm_we_q ? '0 : DmRdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            lat_num_q  <= '0;
            lat_rfwe_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rfwe_q  <= 1'b0;
            wb_num_q   <= '0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            lat_num_q  <= lat_num_d;
            lat_rfwe_q <= lat_rfwe_d;
            wb_valid_q <= wb_valid_d;
            wb_rfwe_q  <= wb_rfwe_d;
            wb_num_q   <= wb_num_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

    assign DmReq        = dm_req_q;
    assign DmWe         = dm_we_q;
    assign DmAddr       = dm_addr_q;
    assign DmWdata      = dm_wdata_q;
    assign WbValid      = wb_valid_q;
    assign WbRfWrEnable = wb_rfwe_q;
    assign WbWrNum      = wb_num_q;
    assign WbData       = wb_data_q;
    assign MisalignErr  = mis_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal cases, then randomized traffic
// checked every cycle against a transaction-level model.
module tb_mem_access_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          InValid, IsLoadInsnIn, IsStoreInsnIn, RfWrEnableIn, Flush;
    logic [DW-1:0] ALUOutIn, RdDataBIn;
    logic [RW-1:0] WrNumIn;
    logic          Stall, DmReq, DmWe, DmAck;
    logic [DW-1:0] DmAddr, DmWdata, DmRdata;
    logic          WbValid, WbRfWrEnable, MisalignErr;
    logic [RW-1:0] WbWrNum;
    logic [DW-1:0] WbData;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .ALUOutIn(ALUOutIn),
        .RdDataBIn(RdDataBIn), .IsLoadInsnIn(IsLoadInsnIn),
        .IsStoreInsnIn(IsStoreInsnIn), .RfWrEnableIn(RfWrEnableIn),
        .WrNumIn(WrNumIn), .Flush(Flush), .Stall(Stall), .DmReq(DmReq),
        .DmWe(DmWe), .DmAddr(DmAddr), .DmWdata(DmWdata), .DmAck(DmAck),
        .DmRdata(DmRdata), .WbValid(WbValid), .WbRfWrEnable(WbRfWrEnable),
        .WbWrNum(WbWrNum), .WbData(WbData), .MisalignErr(MisalignErr)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: at most one outstanding memory transaction, plus the
    // writeback result that the last accepted instruction must produce.
    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [RW-1:0] wr;
        logic          rfwe;
    } txn_t;

    txn_t          pend[$];
    logic          e_wbv = 1'b0, e_wbrf = 1'b0, e_rfk = 1'b0, e_mis = 1'b0;
    logic [RW-1:0] e_wbnum = '0;
    logic [DW-1:0] e_wbdata = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            e_wbv  <= 1'b0;
            e_wbrf <= 1'b0;
            e_rfk  <= 1'b1;
            e_mis  <= 1'b0;
        end else if (pend.size() != 0) begin
            e_mis <= 1'b0;
            if (DmAck) begin
                e_wbv    <= 1'b1;
                e_wbnum  <= pend[0].wr;
                e_wbrf   <= pend[0].rfwe && !pend[0].we;
                e_rfk    <= 1'b1;
                e_wbdata <= pend[0].we ? '0 : DmRdata;
                void'(pend.pop_front());
            end else begin
                e_wbv <= 1'b0;
            end
        end else if (Flush) begin
            e_wbv  <= 1'b0;
            e_wbrf <= 1'b0;
            e_rfk  <= 1'b1;
            e_mis  <= 1'b0;
        end else if (InValid && (IsLoadInsnIn || IsStoreInsnIn)) begin
            if (ALUOutIn % 4 != 0) begin
                e_wbv  <= 1'b1;
                e_wbrf <= 1'b0;
                e_rfk  <= 1'b1;
                e_mis  <= 1'b1;
            end else begin
                pend.push_back('{we: IsStoreInsnIn, addr: ALUOutIn, wdata: RdDataBIn,
                                 wr: WrNumIn, rfwe: RfWrEnableIn});
                e_wbv <= 1'b0;
                e_rfk <= 1'b0;
                e_mis <= 1'b0;
            end
        end else if (InValid) begin
            e_wbv    <= 1'b1;
            e_wbdata <= ALUOutIn;
            e_wbnum  <= WrNumIn;
            e_wbrf   <= RfWrEnableIn;
            e_rfk    <= 1'b1;
            e_mis    <= 1'b0;
        end else begin
            e_wbv <= 1'b0;
            e_rfk <= 1'b0;
            e_mis <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        if (pend.size() != 0) exp_stall = !DmAck;
        else exp_stall = InValid && (IsLoadInsnIn || IsStoreInsnIn) && (ALUOutIn % 4 == 0) && !Flush;
        chk("m_stall", Stall, exp_stall && rst);
        chk("m_dmreq", DmReq, pend.size() != 0);
        if (pend.size() != 0) begin
            chk("m_dmwe", DmWe, pend[0].we);
            chk("m_dmaddr", DmAddr, pend[0].addr);
            chk("m_dmwdata", DmWdata, pend[0].wdata);
        end
        chk("m_wbvalid", WbValid, e_wbv);
        chk("m_misalign", MisalignErr, e_mis);
        if (e_rfk) chk("m_wbrfwe", WbRfWrEnable, e_wbrf);
        if (e_wbv && !e_mis) begin
            chk("m_wbwrnum", WbWrNum, e_wbnum);
            chk("m_wbdata", WbData, e_wbdata);
        end
    end

    task automatic drive(input logic v, input logic ld, input logic st, input logic rf,
                         input logic [RW-1:0] wr, input logic [DW-1:0] alu,
                         input logic [DW-1:0] rdb, input logic fl);
        InValid = v; IsLoadInsnIn = ld; IsStoreInsnIn = st; RfWrEnableIn = rf;
        WrNumIn = wr; ALUOutIn = alu; RdDataBIn = rdb; Flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic          s;
        logic [DW-1:0] a;
        int            kind;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        DmAck = 1'b0;
        DmRdata = '0;
        #3 rst = 1'b0;
        #1;
        chk("rst_wbvalid", WbValid, 0);
        chk("rst_dmreq", DmReq, 0);
        chk("rst_misalign", MisalignErr, 0);
        chk("rst_stall", Stall, 0);
        step();
        rst = 1'b1;

        // non-memory op, accepted on the first edge after reset release
        drive(1, 0, 0, 1, 7, 32'h1234, 0, 0);
        #1 chk("alu_stall", Stall, 0);
        step();
        chk("alu_wbvalid", WbValid, 1);
        chk("alu_wbdata", WbData, 32'h1234);
        chk("alu_wbwrnum", WbWrNum, 7);
        chk("alu_wbrfwe", WbRfWrEnable, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // load, ack arrives in the third WAIT cycle
        drive(1, 1, 0, 1, 3, 32'h100, 0, 0);
        DmRdata = 32'hDEADBEEF;
        #1 chk("ld_stall_accept", Stall, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            DmAck = (k == 2);
            #1;
            chk("ld_dmreq", DmReq, 1);
            chk("ld_dmaddr", DmAddr, 32'h100);
            chk("ld_stall_wait", Stall, (k != 2));
            chk("ld_wbvalid_wait", WbValid, 0);
            step();
        end
        chk("ld_wbvalid", WbValid, 1);
        chk("ld_wbdata", WbData, 32'hDEADBEEF);
        chk("ld_wbwrnum", WbWrNum, 3);
        chk("ld_wbrfwe", WbRfWrEnable, 1);
        chk("ld_dmreq_done", DmReq, 0);
        DmAck = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // store with same-cycle ack
        drive(1, 0, 1, 1, 9, 32'h200, 32'h55, 0);
        #1 chk("st_stall_accept", Stall, 1);
        step();
        DmAck = 1'b1;
        #1;
        chk("st_dmreq", DmReq, 1);
        chk("st_dmwe", DmWe, 1);
        chk("st_dmwdata", DmWdata, 32'h55);
        chk("st_stall_ack", Stall, 0);
        step();
        chk("st_wbvalid", WbValid, 1);
        chk("st_wbrfwe", WbRfWrEnable, 0);
        DmAck = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // misaligned load
        drive(1, 1, 0, 1, 4, 32'h102, 0, 0);
        #1 chk("mis_stall", Stall, 0);
        step();
        chk("mis_dmreq", DmReq, 0);
        chk("mis_err", MisalignErr, 1);
        chk("mis_wbvalid", WbValid, 1);
        chk("mis_wbrfwe", WbRfWrEnable, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mis_err_clear", MisalignErr, 0);

        // flush during WAIT is ignored
        drive(1, 1, 0, 1, 5, 32'h300, 0, 0);
        step();
        Flush = 1'b1;
        DmAck = 1'b1;
        DmRdata = 32'hCAFE;
        #1 chk("fw_stall", Stall, 0);
        step();
        chk("fw_wbvalid", WbValid, 1);
        chk("fw_wbdata", WbData, 32'hCAFE);
        // flush in IDLE kills a valid load
        DmAck = 1'b0;
        drive(1, 1, 0, 1, 6, 32'h400, 0, 1);
        #1 chk("fi_stall", Stall, 0);
        step();
        chk("fi_dmreq", DmReq, 0);
        chk("fi_wbvalid", WbValid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // reset pulse mid-WAIT
        drive(1, 1, 0, 1, 8, 32'h500, 0, 0);
        step();
        chk("rw_dmreq_pre", DmReq, 1);
        rst = 1'b0;
        #1;
        chk("rw_dmreq", DmReq, 0);
        chk("rw_stall", Stall, 0);
        chk("rw_wbvalid", WbValid, 0);
        step();
        rst = 1'b1;
        drive(1, 0, 0, 1, 2, 32'hABC, 0, 0);
        #1 chk("rw_alu_stall", Stall, 0);
        step();
        chk("rw_alu_wbvalid", WbValid, 1);
        chk("rw_alu_wbdata", WbData, 32'hABC);
        chk("rw_alu_wbwrnum", WbWrNum, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic; upstream holds its inputs while stalled
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s = Stall;
            step();
            if (!s) begin
                kind = $urandom_range(0, 3);
                a = $urandom();
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                drive($urandom_range(0, 9) != 0, kind == 1, kind == 2, 1'($urandom()),
                      RW'($urandom()), a, $urandom(), 1'b0);
            end
            Flush = ($urandom_range(0, 9) == 0);
            DmAck = ($urandom_range(0, 2) == 0);
            DmRdata = $urandom();
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of data, address and ALU result.
REQ-002 SHALL have parameter REG_NUM_WIDTH, default 5, meaning the width of the register number.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port InValid, input, 1 bit, meaning an instruction is present from the EX/MEM register.
REQ-006 SHALL have port ALUOutIn, input, DATA_WIDTH, carrying the ALU result or the memory byte address.
REQ-007 SHALL have port RdDataBIn, input, DATA_WIDTH, carrying the store data.
REQ-008 SHALL have ports IsLoadInsnIn, IsStoreInsnIn and RfWrEnableIn, each an input of 1 bit, carrying the decoded control.
REQ-009 SHALL have port WrNumIn, input, REG_NUM_WIDTH, giving the destination register.
REQ-010 SHALL have port Flush, input, 1 bit, a pipeline kill request.
REQ-011 SHALL have port Stall, output, 1 bit; when high, the upstream SHALL hold the EX/MEM register and its inputs here.
REQ-012 SHALL have the following memory-interface ports:
- DmReq, output, 1 bit.
- DmWe, output, 1 bit.
- DmAddr, output, DATA_WIDTH.
- DmWdata, output, DATA_WIDTH.
- DmAck, input, 1 bit.
- DmRdata, input, DATA_WIDTH.
REQ-013 SHALL have the following writeback outputs, all registered:
- WbValid, output, 1 bit.
- WbRfWrEnable, output, 1 bit.
- WbWrNum, output, REG_NUM_WIDTH.
- WbData, output, DATA_WIDTH.
- MisalignErr, output, 1 bit.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and WAIT.
REQ-015 SHALL define "start" as InValid & (IsLoadInsnIn | IsStoreInsnIn) & (ALUOutIn[1:0]==0) & !Flush, evaluated in IDLE only.
REQ-016 In IDLE with start, SHALL take the following actions at the next edge:
- Go to WAIT.
- Set DmReq=1, DmWe=IsStoreInsnIn, DmAddr=ALUOutIn, DmWdata=RdDataBIn.
- Latch WrNumIn and RfWrEnableIn.
- Set WbValid=0.
REQ-017 SHALL hold DmReq, DmWe, DmAddr and DmWdata stable while in WAIT until the cycle in which DmAck=1.
REQ-018 In WAIT with DmAck=1, SHALL take the following actions at the next edge:
- Return to IDLE.
- Set DmReq=0.
- Set WbValid=1 and WbWrNum to the latched value.
- Set WbRfWrEnable to the latched RfWrEnable & !DmWe.
- Set WbData to DmRdata for a load, or 0 for a store.
REQ-019 SHALL drive Stall combinationally as (IDLE & start) | (WAIT & !DmAck).
REQ-020 In IDLE with InValid, not a load or store, and !Flush, SHALL register WbValid=1, WbData=ALUOutIn, WbWrNum=WrNumIn and WbRfWrEnable=RfWrEnableIn, giving a latency of 1 cycle.
REQ-021 For an aligned load or store, SHALL have a latency of 1 cycle plus the number of cycles until DmAck; the minimum is 2 edges from acceptance to WbValid.
REQ-022 For a load or store with ALUOutIn[1:0]!=0 in IDLE, SHALL take the following actions:
- Issue no DmReq.
- Register WbValid=1, WbRfWrEnable=0 and MisalignErr=1 for exactly one cycle.
- Not assert Stall.
REQ-023 In IDLE with Flush=1, SHALL register WbValid=0, WbRfWrEnable=0 and MisalignErr=0 regardless of InValid; Flush SHALL take priority over start and misalignment.
REQ-024 In WAIT, SHALL ignore Flush; the outstanding memory transaction SHALL always complete.
REQ-025 SHALL ignore DmAck while in IDLE.
REQ-026 In IDLE with InValid=0 and no Flush, SHALL register WbValid=0 and MisalignErr=0.
REQ-027 SHALL keep MisalignErr at 0 in every cycle except the one defined in REQ-022.

Reset
REQ-028 On rst=0, SHALL set the FSM to IDLE and all registered outputs to 0 immediately, independent of clk.
REQ-029 On reset asserted during WAIT, SHALL drop DmReq immediately and discard the pending writeback.
REQ-030 After rst deasserts, SHALL accept a new instruction on the first clock edge.

Verification
REQ-031 Non-memory op: InValid=1, ALUOutIn=0x1234, WrNumIn=7, RfWrEnableIn=1 -> after 1 edge WbValid=1, WbData=0x1234, WbWrNum=7, WbRfWrEnable=1, Stall=0 throughout.
REQ-032 Load with 3-cycle ack delay: ALUOutIn=0x100, DmRdata=0xDEADBEEF -> DmReq=1 with DmAddr=0x100 held for 3 cycles, Stall=1 until the ack cycle, then WbData=0xDEADBEEF and WbValid=1 on the following edge.
REQ-033 Store with same-cycle ack: ALUOutIn=0x200, RdDataBIn=0x55 -> DmWe=1, DmWdata=0x55, then WbValid=1 with WbRfWrEnable=0 two edges after acceptance.
REQ-034 Misaligned load at ALUOutIn=0x102 -> DmReq stays 0, MisalignErr=1 for one cycle, WbRfWrEnable=0.
REQ-035 Flush asserted during WAIT -> transaction completes and WbValid=1; Flush asserted in IDLE with a valid load -> no DmReq and WbValid=0.
REQ-036 rst pulsed low mid-WAIT -> DmReq=0 and Stall=0 within the reset cycle, and a following non-memory op completes normally.
